// File: rtl/aes_avalon_interface_if.sv
// Avalon-MM slave bus bundle for aes_avalon_interface.
// Signals:
//   AVL_CS        chip select, qualifies AVL_READ / AVL_WRITE
//   AVL_READ      read strobe
//   AVL_WRITE     write strobe
//   AVL_ADDR      word address 0-15
//   AVL_BYTE_EN   per-byte write enables
//   AVL_WRITEDATA write data
//   AVL_READDATA  registered read data (driven by the slave)
interface aes_avalon_interface_if;
    logic        AVL_CS;
    logic        AVL_READ;
    logic        AVL_WRITE;
    logic [3:0]  AVL_ADDR;
    logic [3:0]  AVL_BYTE_EN;
    logic [31:0] AVL_WRITEDATA;
    logic [31:0] AVL_READDATA;

    modport master (
        output AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_BYTE_EN, AVL_WRITEDATA,
        input  AVL_READDATA
    );

    modport slave (
        input  AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_BYTE_EN, AVL_WRITEDATA,
        output AVL_READDATA
    );
endinterface

// File: rtl/aes_avalon_interface.sv
// Register file between an Avalon-MM master and the AES decryption core.
// Software loads key (regs 0-3) and ciphertext (regs 4-7), sets CTRL.START (reg 14),
// and the block holds AES_START/AES_KEY/AES_MSG_ENC stable until the core's AES_DONE,
// then captures AES_MSG_DEC into read-only regs 8-11 and sets STATUS.DONE (reg 15).
// Ports:
//   CLK, RESET_N          clock, asynchronous active-low reset
//   avl                   Avalon-MM slave bundle (1-cycle registered reads)
//   AES_START             run request to the core (high only while running)
//   AES_DONE              core completion
//   AES_KEY, AES_MSG_ENC  {reg0..reg3}, {reg4..reg7}
//   AES_MSG_DEC           plaintext from the core
//   EXPORT_DATA           {reg0[31:16], reg3[15:0]} for hex displays
//   AES_IRQ               completion interrupt, only when AES_IRQ_EN is defined
module aes_avalon_interface (
    input  logic                   CLK,
    input  logic                   RESET_N,
    aes_avalon_interface_if.slave  avl,
    output logic                   AES_START,
    input  logic                   AES_DONE,
    output logic [127:0]           AES_KEY,
    output logic [127:0]           AES_MSG_ENC,
    input  logic [127:0]           AES_MSG_DEC,
    output logic [31:0]            EXPORT_DATA
`ifdef AES_IRQ_EN
    ,
    output logic                   AES_IRQ
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e      state_q, state_d;
    logic [31:0] key_q [4];
    logic [31:0] key_d [4];
    logic [31:0] msg_q [4];
    logic [31:0] msg_d [4];
    logic [31:0] pt_q  [4];
    logic [31:0] pt_d  [4];
    logic        start_q, start_d;
    logic        done_q, done_d;
    logic        irq_q, irq_d;
    logic [31:0] rdata_q, rdata_d;
    logic        busy;

    logic wr_en, rd_en, ctrl_wr, launch, stop, capture;

    assign wr_en   = avl.AVL_CS & avl.AVL_WRITE;
    assign rd_en   = avl.AVL_CS & avl.AVL_READ;
    assign ctrl_wr = wr_en & (avl.AVL_ADDR == 4'd14) & avl.AVL_BYTE_EN[0];
    assign launch  = (state_q == StIdle) & ctrl_wr & avl.AVL_WRITEDATA[0];
    assign stop    = ctrl_wr & ~avl.AVL_WRITEDATA[0];
    // An abort write on the same edge as AES_DONE wins: nothing is captured.
    assign capture = (state_q == StRun) & AES_DONE & ~stop;

    function automatic logic [31:0] be_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= StIdle;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (launch) state_d = StRun;
            StRun:   if (stop) state_d = StIdle;
                     else if (AES_DONE) state_d = StFin;
            StFin:   if (stop) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy      = (state_q == StRun);
        AES_START = (state_q == StRun);
    end

    // Register-file next state
    always_comb begin
        key_d   = key_q;
        msg_d   = msg_q;
        pt_d    = pt_q;
        start_d = start_q;
        done_d  = done_q;
        irq_d   = irq_q;
        rdata_d = rdata_q;

        // Key/ciphertext are frozen while the core is running.
        if (wr_en && (state_q != StRun) && (avl.AVL_ADDR < 4'd8)) begin
            if (avl.AVL_ADDR[2]) begin
                msg_d[avl.AVL_ADDR[1:0]] = be_merge(msg_q[avl.AVL_ADDR[1:0]],
                                                    avl.AVL_WRITEDATA, avl.AVL_BYTE_EN);
            end else begin
                key_d[avl.AVL_ADDR[1:0]] = be_merge(key_q[avl.AVL_ADDR[1:0]],
                                                    avl.AVL_WRITEDATA, avl.AVL_BYTE_EN);
            end
        end
        if (ctrl_wr) start_d = avl.AVL_WRITEDATA[0];
        if (launch)  done_d  = 1'b0;
        if (capture) begin
            pt_d[0] = AES_MSG_DEC[127:96];
            pt_d[1] = AES_MSG_DEC[95:64];
            pt_d[2] = AES_MSG_DEC[63:32];
            pt_d[3] = AES_MSG_DEC[31:0];
            done_d  = 1'b1;
        end

        // Clear first so a coincident capture sets it.
        if ((wr_en && (avl.AVL_ADDR == 4'd15)) || launch) irq_d = 1'b0;
        if (capture) irq_d = 1'b1;

        // Reads see pre-edge contents, so read-during-write returns the old value.
        if (rd_en) begin
            case (avl.AVL_ADDR)
                4'd0, 4'd1, 4'd2, 4'd3:     rdata_d = key_q[avl.AVL_ADDR[1:0]];
                4'd4, 4'd5, 4'd6, 4'd7:     rdata_d = msg_q[avl.AVL_ADDR[1:0]];
                4'd8, 4'd9, 4'd10, 4'd11:   rdata_d = pt_q[avl.AVL_ADDR[1:0]];
                4'd14:                      rdata_d = {30'd0, busy, start_q};
                4'd15:                      rdata_d = {31'd0, done_q};
                default:                    rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 4; i++) begin
                key_q[i] <= 32'd0;
                msg_q[i] <= 32'd0;
                pt_q[i]  <= 32'd0;
            end
            start_q <= 1'b0;
            done_q  <= 1'b0;
            irq_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            key_q   <= key_d;
            msg_q   <= msg_d;
            pt_q    <= pt_d;
            start_q <= start_d;
            done_q  <= done_d;
            irq_q   <= irq_d;
            rdata_q <= rdata_d;
        end
    end

    assign avl.AVL_READDATA = rdata_q;
    assign AES_KEY          = {key_q[0], key_q[1], key_q[2], key_q[3]};
    assign AES_MSG_ENC      = {msg_q[0], msg_q[1], msg_q[2], msg_q[3]};
    assign EXPORT_DATA      = {key_q[0][31:16], key_q[3][15:0]};

`ifdef AES_IRQ_EN
    assign AES_IRQ = irq_q;
`else
    // Interrupt state is still tracked but not exported in this build.
    logic irq_unused;
    assign irq_unused = irq_q;
`endif

endmodule

// File: tb/tb_aes_avalon_interface.sv
module tb_aes_avalon_interface;

    logic CLK = 1'b0;
    logic RESET_N;
    always #5 CLK = ~CLK;

    aes_avalon_interface_if avl();

    logic         AES_START;
    logic         AES_DONE;
    logic [127:0] AES_KEY;
    logic [127:0] AES_MSG_ENC;
    logic [127:0] AES_MSG_DEC;
    logic [31:0]  EXPORT_DATA;
`ifdef AES_IRQ_EN
    logic         AES_IRQ;
`endif

    aes_avalon_interface dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .avl         (avl),
        .AES_START   (AES_START),
        .AES_DONE    (AES_DONE),
        .AES_KEY     (AES_KEY),
        .AES_MSG_ENC (AES_MSG_ENC),
        .AES_MSG_DEC (AES_MSG_DEC),
        .EXPORT_DATA (EXPORT_DATA)
`ifdef AES_IRQ_EN
        ,
        .AES_IRQ     (AES_IRQ)
`endif
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q [$];

    // Reference model of the software-visible register map
    logic [31:0] m_reg [16];
    bit          m_running, m_finished, m_start, m_done, m_irq;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = 32'd0;
        m_running = 0; m_finished = 0; m_start = 0; m_done = 0; m_irq = 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] a);
        if (a < 4'd12) return m_reg[a];
        if (a == 4'd14) return {30'd0, m_running, m_start};
        if (a == 4'd15) return {31'd0, m_done};
        return 32'd0;
    endfunction

    function automatic void model_step(input bit wr, input logic [3:0] a, input logic [3:0] be,
                                       input logic [31:0] wd, input bit cd,
                                       input logic [127:0] dec);
        bit was_running = m_running;
        bit aborted = 0;
        if (wr) begin
            if (a < 4'd8 && !was_running) begin
                for (int b = 0; b < 4; b++) if (be[b]) m_reg[a][8*b +: 8] = wd[8*b +: 8];
            end
            if (a == 4'd15) m_irq = 0;
            if (a == 4'd14 && be[0]) begin
                if (was_running) begin
                    if (!wd[0]) begin m_running = 0; aborted = 1; end
                end else if (m_finished) begin
                    if (!wd[0]) m_finished = 0;
                end else if (wd[0]) begin
                    m_running = 1; m_done = 0; m_irq = 0;
                end
                m_start = wd[0];
            end
        end
        if (was_running && cd && !aborted) begin
            m_reg[8]  = dec[127:96];
            m_reg[9]  = dec[95:64];
            m_reg[10] = dec[63:32];
            m_reg[11] = dec[31:0];
            m_done = 1; m_irq = 1; m_running = 0; m_finished = 1;
        end
    endfunction

    task automatic check_outputs();
        chk("aes_start", {127'd0, AES_START}, {127'd0, m_running});
        chk("aes_key", AES_KEY, {m_reg[0], m_reg[1], m_reg[2], m_reg[3]});
        chk("aes_msg_enc", AES_MSG_ENC, {m_reg[4], m_reg[5], m_reg[6], m_reg[7]});
        chk("export_data", {96'd0, EXPORT_DATA}, {96'd0, m_reg[0][31:16], m_reg[3][15:0]});
`ifdef AES_IRQ_EN
        chk("aes_irq", {127'd0, AES_IRQ}, {127'd0, m_irq});
`endif
    endtask

    // One bus cycle, entered and left at a falling edge.
    task automatic bus_op(input bit rd, input bit wr, input logic [3:0] a, input logic [3:0] be,
                          input logic [31:0] wd, input bit cd, input logic [127:0] dec);
        avl.AVL_CS        = rd | wr;
        avl.AVL_READ      = rd;
        avl.AVL_WRITE     = wr;
        avl.AVL_ADDR      = a;
        avl.AVL_BYTE_EN   = be;
        avl.AVL_WRITEDATA = wd;
        AES_DONE          = cd;
        AES_MSG_DEC       = dec;
        if (rd) exp_q.push_back(model_read(a));
        @(posedge CLK);
        model_step(wr, a, be, wd, cd, dec);
        @(negedge CLK);
        avl.AVL_CS = 0; avl.AVL_READ = 0; avl.AVL_WRITE = 0;
        AES_DONE = 0;
        check_outputs();
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
        bus_op(0, 1, a, be, d, 0, 128'd0);
    endtask

    task automatic rd(input logic [3:0] a);
        bus_op(1, 0, a, 4'h0, 32'd0, 0, 128'd0);
    endtask

    task automatic idle_op(input bit cd, input logic [127:0] dec);
        bus_op(0, 0, 4'd0, 4'h0, 32'd0, cd, dec);
    endtask

    task automatic full_run(input logic [127:0] k, input logic [127:0] ct,
                            input logic [127:0] pt, input bit probe);
        for (int i = 0; i < 4; i++) begin
            wr(4'(i), 4'hF, k[127 - 32*i -: 32]);
            wr(4'(4 + i), 4'hF, ct[127 - 32*i -: 32]);
        end
        wr(4'd14, 4'hF, 32'd1);
        for (int c = 1; c < 20; c++) begin
            if (probe && c == 3) wr(4'd4, 4'hF, 32'h1234_5678);
            else if (probe && c == 4) rd(4'd4);
            else if (c % 4 == 0) rd(4'd14);
            else idle_op(0, 128'd0);
        end
        idle_op(1, pt);
        for (int i = 8; i < 12; i++) rd(4'(i));
        rd(4'd15);
        rd(4'd14);
        if (probe) begin
            wr(4'd4, 4'hF, 32'h1234_5678);
            rd(4'd4);
        end
        wr(4'd15, 4'hF, 32'd0);
        wr(4'd14, 4'h1, 32'd0);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Read-data monitor: compares against the expected-value queue.
    initial begin
        bit sampled;
        logic [31:0] e;
        forever begin
            @(posedge CLK);
            sampled = avl.AVL_CS && avl.AVL_READ && RESET_N;
            @(negedge CLK);
            if (sampled) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL readdata: got %h with no expected value queued",
                             avl.AVL_READDATA);
                end else begin
                    e = exp_q.pop_front();
                    chk("readdata", {96'd0, avl.AVL_READDATA}, {96'd0, e});
                end
            end
        end
    end

    initial begin
        logic [127:0] k, ct, pt;
        int r;
        avl.AVL_CS = 0; avl.AVL_READ = 0; avl.AVL_WRITE = 0;
        avl.AVL_ADDR = 0; avl.AVL_BYTE_EN = 0; avl.AVL_WRITEDATA = 0;
        AES_DONE = 0; AES_MSG_DEC = 0;
        RESET_N = 0;
        model_reset();
        repeat (2) @(negedge CLK);
        RESET_N = 1;
        check_outputs();
        chk("rst_readdata", {96'd0, avl.AVL_READDATA}, 128'd0);
        for (int i = 0; i < 16; i++) rd(4'(i));

        wr(4'd0, 4'b0101, 32'hDEAD_BEEF);
        rd(4'd0);
        chk("be_key_msw", {96'd0, AES_KEY[127:96]}, {96'd0, 32'h00AD_00EF});

        // Known-answer run with lock probes in RUN and FIN
        full_run(128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                 128'h00112233445566778899aabbccddeeff, 1);

        // Read during write to the same address returns the old value
        bus_op(1, 1, 4'd5, 4'hF, 32'hCAFE_F00D, 0, 128'd0);
        rd(4'd5);

        // AES_DONE outside RUN is ignored
        idle_op(1, rand128());
        rd(4'd8);

        // Abort racing AES_DONE
        wr(4'd14, 4'h1, 32'd1);
        repeat (5) idle_op(0, 128'd0);
        bus_op(0, 1, 4'd14, 4'h1, 32'd0, 1, rand128());
        for (int i = 8; i < 12; i++) rd(4'(i));
        rd(4'd15);
        rd(4'd14);

        // Randomised traffic, including random runs and core completions
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 2) begin
                logic [3:0] a;
                a = 4'($urandom_range(0, 15));
                if (a == 4'd14) a = 4'd13;
                wr(a, 4'($urandom_range(0, 15)), $urandom);
            end else if (r <= 5) begin
                rd(4'($urandom_range(0, 15)));
            end else if (r == 6) begin
                bus_op(0, 1, 4'd14, 4'h1, {31'd0, 1'($urandom_range(0, 1))},
                       ($urandom_range(0, 7) == 0), rand128());
            end else if (r == 7 && n % 50 == 7) begin
                k = rand128(); ct = rand128(); pt = k ^ ct;
                full_run(k, ct, pt, 0);
            end else begin
                idle_op(($urandom_range(0, 5) == 0), rand128());
            end
        end

        // Reset asserted mid-run drops AES_START without a clock edge
        wr(4'd14, 4'h1, 32'd0);
        wr(4'd14, 4'h1, 32'd1);
        idle_op(0, 128'd0);
        #2;
        RESET_N = 0;
        #1;
        chk("rst_async_start", {127'd0, AES_START}, 128'd0);
        model_reset();
        @(negedge CLK);
        RESET_N = 1;
        check_outputs();
        for (int i = 0; i < 16; i++) rd(4'(i));

        repeat (3) @(negedge CLK);
        chk("exp_q_drained", 128'(exp_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_avalon_interface.md
# aes_avalon_interface

Avalon-MM slave register file that sits directly upstream of the AES decryption core. Software writes the 128-bit key and 128-bit ciphertext through the bus and launches a decryption. The block drives the core's START/KEY/MSG_ENC inputs and holds them stable for the whole run. On the core's DONE it captures the plaintext into read-only registers and raises a status flag.

## Interface
- No parameters; the register map is fixed at 16 × 32 bits.
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- AVL_CS  in  1  chip select; qualifies AVL_READ and AVL_WRITE.
- AVL_READ  in  1  read strobe.
- AVL_WRITE  in  1  write strobe.
- AVL_ADDR  in  4  word address 0–15.
- AVL_BYTE_EN  in  4  byte enables for writes; bit n enables WRITEDATA[8n+7:8n].
- AVL_WRITEDATA  in  32  write data.
- AVL_READDATA  out  32  registered read data.
- AES_START  out  1  level request to the core.
- AES_DONE  in  1  core completion flag.
- AES_KEY  out  128  {reg0, reg1, reg2, reg3}.
- AES_MSG_ENC  out  128  {reg4, reg5, reg6, reg7}.
- AES_MSG_DEC  in  128  plaintext from the core.
- EXPORT_DATA  out  32  {reg0[31:16], reg3[15:0]}, for hex displays.
- AES_IRQ  out  1  completion interrupt; present only with AES_IRQ_EN.

## Operation
- Register map:
  - 0–3: key, MSW first. Read/write.
  - 4–7: ciphertext, MSW first. Read/write.
  - 8–11: plaintext, MSW first. Read-only; bus writes are ignored.
  - 12–13: reserved. Read 0; writes ignored.
  - 14: CTRL. Bit0 = START (read/write); bit1 = BUSY (read-only). Other bits read 0.
  - 15: STATUS. Bit0 = DONE (read-only). Other bits read 0.
- A write is accepted when AVL_CS & AVL_WRITE. Only enabled bytes are updated.
- FSM states IDLE, RUN, FIN; reset state is IDLE.
  - IDLE → RUN: a write to reg14 with BYTE_EN[0]=1 and WRITEDATA[0]=1. START is set, and DONE is cleared in the same edge.
  - RUN → FIN: AES_DONE=1 sampled on an edge. At that edge, regs 8–11 <= AES_MSG_DEC and DONE <= 1.
  - RUN → IDLE (abort): a write to reg14 with bit0=0. Plaintext regs and DONE are left unchanged.
  - FIN → IDLE: a write to reg14 with bit0=0. DONE stays set until the next start.
  - FIN, write of bit0=1: START bit stored; no new run is launched until software has written 0.
- Outputs by state:
  - AES_START=1 only in RUN.
  - BUSY=1 only in RUN.
- Input locking: writes to regs 0–7 are ignored while in RUN, so AES_KEY and AES_MSG_ENC are constant for the whole run. Writes to 0–7 are accepted in IDLE and FIN.
- AES_DONE outside RUN is ignored.
- Simultaneous AES_DONE and an abort write in RUN: abort wins. State goes to IDLE, no capture, DONE unchanged.

## Timing
- Reset values (asynchronous assert; release takes effect on the next edge):
  - All registers 0.
  - State IDLE.
  - AES_START=0, AVL_READDATA=0, AES_KEY=0, AES_MSG_ENC=0, EXPORT_DATA=0, AES_IRQ=0.
- Write latency: register contents and outputs change on the edge that samples the write. AES_START rises in the cycle after the launching write.
- Read latency: fixed 1 cycle. AVL_READDATA is loaded on the edge that samples AVL_CS & AVL_READ and holds its value otherwise. No wait states.
- Read during write to the same address returns the pre-write value.
- Capture: plaintext regs are visible on the bus in the cycle after the AES_DONE edge; the earliest read returns them 2 cycles after that edge. AES_START falls in the cycle after the capture edge.
- Reset asserted mid-RUN: AES_START drops immediately (asynchronously); all registers clear.

## Configuration
- AES_IRQ_EN defined:
  - AES_IRQ output exists and is registered.
  - It is set on the RUN→FIN capture edge.
  - It is cleared by any write to reg15, or on entering RUN. A set and a clear on the same edge: set wins.
- AES_IRQ_EN undefined: AES_IRQ port is absent and all other behaviour is identical.

## Test plan
- Reset: RESET_N low mid-cycle -> AES_START=0 immediately; reads of regs 0–15 return 0.
- Byte enables: write 0xDEADBEEF to reg0 with BYTE_EN=0b0101 -> reg0 reads 0x00AD00EF, and AES_KEY[127:96]=0x00AD00EF.
- Full decrypt (behavioural core raises DONE 20 cycles after START):
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, write reg14=1.
  - Response: BUSY=1 during the run; then regs 8–11 = 00112233, 44556677, 8899aabb, ccddeeff; DONE=1; AES_START=0.
- Lock: write reg4=0x12345678 during RUN -> AES_MSG_ENC is unchanged and reg4 reads its old value. Repeat in FIN -> write is accepted.
- Abort race: write reg14=0 on the same edge as AES_DONE=1 -> state IDLE, regs 8–11 unchanged, DONE=0.
- With AES_IRQ_EN: AES_IRQ rises on the capture edge. A write to reg15 -> AES_IRQ=0 the next cycle.
